call_panel: RTL

Front-end for the elevator controller's request inputs. It conditions the raw board pushbuttons (five car buttons, five hall buttons, door open, door shut) into clean requests. Each car/hall request is held asserted until the controller acknowledges it through the matching indicator bit (`btnidccar`/`btnidcout`), or until a timeout expires. It sits between the board switches and the destination/indicator logic, driving that logic's `btncar`, `btnout`, `open` and `shut` inputs.

---
 rtl/elevator_pkg.sv | 16 +
 rtl/btn_debounce.sv | 59 +++++
 rtl/call_panel.sv | 127 ++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator front-end and controller: floor count,
// request FSM encoding and default timing constants.
package elevator_pkg;

  localparam int NFLOOR = 5;

  localparam logic [15:0] DB_CYCLES_DEFAULT   = 16'd50000;
  localparam logic [7:0]  ACK_TIMEOUT_DEFAULT = 8'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HELD = 2'd2
  } req_state_e;

endpackage

// File: rtl/btn_debounce.sv
// One raw pushbutton: 2-FF synchronizer, stability counter, debounced level
// and a one-cycle pulse on each qualified debounced rising edge.
module btn_debounce
  import elevator_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw_i,
  output logic db_o,
  output logic rise_o
);

  logic        meta_q;
  logic        sync_q;
  logic        db_q;
  logic        rise_q;
  logic        armed_q;
  logic [1:0]  settle_q;
  logic [15:0] cnt_q;

  // A button already held when reset releases must be seen low once before
  // any press counts, so arming waits for the synchronizer to fill and read 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      db_q     <= 1'b0;
      rise_q   <= 1'b0;
      armed_q  <= 1'b0;
      settle_q <= 2'd0;
      cnt_q    <= 16'd0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      rise_q <= 1'b0;
      if (settle_q != 2'd2) begin
        settle_q <= settle_q + 2'd1;
      end
      if (settle_q == 2'd2 && !sync_q) begin
        armed_q <= 1'b1;
      end
      if (sync_q == db_q) begin
        cnt_q <= 16'd0;
      end else if (cnt_q == DB_CYCLES - 16'd1) begin
        cnt_q  <= 16'd0;
        db_q   <= sync_q;
        rise_q <= sync_q & armed_q;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/call_panel.sv
// Conditions the raw car/hall/door buttons into held requests (released by
// indicator acknowledge or timeout) and single-cycle door command pulses.
module call_panel
  import elevator_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter logic [7:0]  ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [NFLOOR-1:0] raw_car,
  input  logic [NFLOOR-1:0] raw_out,
  input  logic              raw_open,
  input  logic              raw_shut,
  input  logic [NFLOOR-1:0] btnidccar,
  input  logic [NFLOOR-1:0] btnidcout,
  output logic [NFLOOR-1:0] btncar,
  output logic [NFLOOR-1:0] btnout,
  output logic              open,
  output logic              shut
);

  localparam int NREQ = 2 * NFLOOR;

  logic [NREQ-1:0] rawReq;
  logic [NREQ-1:0] ackReq;
  logic [NREQ-1:0] dbReq;
  logic [NREQ-1:0] riseReq;
  logic [NREQ-1:0] reqBits;
  logic            openDb;
  logic            openRise;
  logic            shutDb;
  logic            shutRise;
  logic            open_q;
  logic            shut_q;

  assign rawReq = {raw_out, raw_car};
  assign ackReq = {btnidcout, btnidccar};

  for (genvar g = 0; g < NREQ; g++) begin : g_db
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk    (clk),
      .resetn (resetn),
      .raw_i  (rawReq[g]),
      .db_o   (dbReq[g]),
      .rise_o (riseReq[g])
    );
  end

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_open (
    .clk    (clk),
    .resetn (resetn),
    .raw_i  (raw_open),
    .db_o   (openDb),
    .rise_o (openRise)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_shut (
    .clk    (clk),
    .resetn (resetn),
    .raw_i  (raw_shut),
    .db_o   (shutDb),
    .rise_o (shutRise)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      open_q <= 1'b0;
      shut_q <= 1'b0;
    end else begin
      open_q <= enable & openRise & openDb;
      shut_q <= enable & shutRise & shutDb;
    end
  end

  // Per-bit request FSM; ack only counts once the bit is already in REQ, so a
  // pre-acknowledged floor still yields exactly one request cycle.
  for (genvar g = 0; g < NREQ; g++) begin : g_req
    req_state_e state_q;
    logic [7:0] timer_q;
    logic       req_q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        state_q <= IDLE;
        timer_q <= 8'd0;
        req_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (riseReq[g] && enable) begin
              state_q <= REQ;
              timer_q <= 8'd0;
              req_q   <= 1'b1;
            end
          end
          REQ: begin
            if (ackReq[g] || timer_q == ACK_TIMEOUT || !enable) begin
              state_q <= HELD;
              req_q   <= 1'b0;
            end else begin
              timer_q <= timer_q + 8'd1;
            end
          end
          HELD: begin
            if (!dbReq[g]) begin
              state_q <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        endcase
      end
    end

    assign reqBits[g] = req_q;
  end

  assign btncar = reqBits[NFLOOR-1:0];
  assign btnout = reqBits[NREQ-1:NFLOOR];
  assign open   = open_q;
  assign shut   = shut_q;

endmodule
